// File: rtl/hi_xcorr_ssp_sched.sv
// rtl/hi_xcorr_ssp_sched.sv - correlator result FIFO and SSP frame serializer
// Packs I/Q (optionally with reader AM bits) into 16-bit words and ships them MSB first.
module hi_xcorr_ssp_sched #(
  parameter int DEPTH = 4
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       corr_valid,
  input  logic [7:0] corr_i,
  input  logic [7:0] corr_q,
  input  logic       snoop,
  input  logic       am_bit,
  input  logic [1:0] clk_div,
  input  logic       clr_ovf,
  output logic       ssp_clk,
  output logic       ssp_din,
  output logic       ssp_frame,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_am_prev;
  logic          r_pend;
  logic [15:0]   r_pend_word;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [14:0]   r_sr;
  logic [3:0]    r_bit;
  logic [3:0]    r_cnt;
  logic [1:0]    r_cd;
  logic          r_din;
  logic          r_ovf;
  logic [7:0]    r_drops;

  logic [15:0]   w_word;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [3:0]    w_pmax;
  logic          w_bit_end;

  assign w_word    = snoop ? {corr_i[7:1], r_am_prev, corr_q[7:1], am_bit} : {corr_i, corr_q};
  assign w_pop     = (r_state == S_LOAD);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push    = r_pend && (!w_full || w_pop);
  assign w_drop    = r_pend && !w_push;
  assign w_pmax    = 4'((5'd2 << r_cd) - 5'd1);
  assign w_bit_end = (r_cnt == w_pmax);

  // One-cycle input register gives the two-edge push-to-LOAD latency.
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_pend      <= 1'b0;
      r_pend_word <= 16'h0000;
      r_am_prev   <= 1'b0;
    end else begin
      r_pend <= corr_valid;
      if (corr_valid) begin
        r_pend_word <= w_word;
        r_am_prev   <= am_bit;
      end
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (w_push) r_mem[r_wr_ptr] <= r_pend_word;
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_drops  <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (clr_ovf) begin
        r_ovf   <= 1'b0;
        r_drops <= 8'd0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drops != 8'hFF) r_drops <= r_drops + 8'd1;
      end
    end
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // GAP goes straight to LOAD when more work is queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_bit_end && (r_bit == 4'd0)) w_state_nxt = S_GAP;
      S_GAP:   if (w_bit_end) w_state_nxt = (r_count != '0) ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_sr  <= 15'h0000;
      r_bit <= 4'd0;
      r_cnt <= 4'd0;
      r_cd  <= 2'd0;
      r_din <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_din <= r_mem[r_rd_ptr][15];
          r_sr  <= r_mem[r_rd_ptr][14:0];
          r_bit <= 4'd15;
          r_cnt <= 4'd0;
          r_cd  <= clk_div;
        end
        S_SHIFT: begin
          if (w_bit_end) begin
            r_cnt <= 4'd0;
            if (r_bit != 4'd0) begin
              r_bit <= r_bit - 4'd1;
              r_din <= r_sr[14];
              r_sr  <= {r_sr[13:0], 1'b0};
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_GAP:   r_cnt <= w_bit_end ? 4'd0 : r_cnt + 4'd1;
        default: r_cnt <= 4'd0;
      endcase
    end
  end

  // High half of each bit period is the upper 2^clk_div counts.
  assign ssp_clk    = (r_state == S_SHIFT) && r_cnt[r_cd];
  assign ssp_frame  = (r_state == S_SHIFT) && (r_bit == 4'd15);
  assign ssp_din    = r_din;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);
  assign overflow   = r_ovf;
  assign drop_count = r_drops;

endmodule

// File: tb/tb_hi_xcorr_ssp_sched.sv
// tb/tb_hi_xcorr_ssp_sched.sv - self-checking bench for hi_xcorr_ssp_sched
module tb_hi_xcorr_ssp_sched;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       corr_valid = 1'b0;
  logic [7:0] corr_i = 8'h00;
  logic [7:0] corr_q = 8'h00;
  logic       snoop = 1'b0;
  logic       am_bit = 1'b0;
  logic [1:0] clk_div = 2'd0;
  logic       clr_ovf = 1'b0;
  logic       ssp_clk, ssp_din, ssp_frame, busy, overflow;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  hi_xcorr_ssp_sched #(.DEPTH(DEPTH)) dut (
    .ck_1356meg(clk), .reset(reset), .corr_valid(corr_valid), .corr_i(corr_i),
    .corr_q(corr_q), .snoop(snoop), .am_bit(am_bit), .clk_div(clk_div),
    .clr_ovf(clr_ovf), .ssp_clk(ssp_clk), .ssp_din(ssp_din), .ssp_frame(ssp_frame),
    .busy(busy), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k counts cycles since LOAD; 1..16P is the shifting window, then P gap cycles.
  logic [15:0] m_q[$];
  logic [15:0] m_word = 16'h0;
  logic [15:0] m_pw = 16'h0;
  bit          m_act = 0, m_pend = 0, m_amp = 0, m_ovf = 0, m_din = 0;
  int          m_k = 0, m_p = 2, m_drops = 0;

  task automatic model_step();
    int  old_size;
    bit  drop;
    if (reset) begin
      m_q.delete();
      m_act = 0; m_pend = 0; m_amp = 0; m_ovf = 0; m_din = 0;
      m_k = 0; m_drops = 0;
      return;
    end
    old_size = m_q.size();
    if (m_act) begin
      if (m_k == 0) begin
        m_word = m_q.pop_front();
        m_p    = 2 << clk_div;
        m_din  = m_word[15];
        m_k    = 1;
      end else if (m_k == 17 * m_p) begin
        if (old_size > 0) m_k = 0;
        else m_act = 0;
      end else begin
        m_k++;
        if (m_k <= 16 * m_p && (m_k - 1) % m_p == 0) m_din = m_word[15 - (m_k - 1) / m_p];
      end
    end else if (old_size > 0) begin
      m_act = 1;
      m_k   = 0;
    end
    drop = 0;
    if (m_pend) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pw);
      else drop = 1;
    end
    if (clr_ovf) begin
      m_ovf = 0; m_drops = 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
    m_pend = corr_valid;
    if (corr_valid) begin
      m_pw  = snoop ? {corr_i[7:1], m_amp, corr_q[7:1], am_bit} : {corr_i, corr_q};
      m_amp = am_bit;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    bit shifting, e_clk, e_frame;
    @(negedge clk);
    shifting = m_act && m_k >= 1 && m_k <= 16 * m_p;
    e_clk    = shifting && ((m_k - 1) % m_p) >= m_p / 2;
    e_frame  = m_act && m_k >= 1 && m_k <= m_p;
    chk("ssp_clk", ssp_clk, e_clk);
    chk("ssp_frame", ssp_frame, e_frame);
    chk("ssp_din", ssp_din, m_din);
    chk("busy", busy, (m_act || m_q.size() > 0) ? 1 : 0);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
  end

  // Deserialize on rising ssp_clk; a word is complete after 16 bits starting at a frame bit.
  logic [15:0] cap_q[$];
  logic [15:0] cap_w = 16'h0;
  int          cap_n = 0, n_pulse = 0, n_frame = 0;
  initial forever begin
    @(posedge ssp_clk);
    if (ssp_frame) begin
      cap_w = {15'h0, ssp_din};
      cap_n = 1;
      n_frame++;
    end else begin
      cap_w = {cap_w[14:0], ssp_din};
      cap_n++;
    end
    n_pulse++;
    if (cap_n == 16) cap_q.push_back(cap_w);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    corr_valid = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    n_pulse = 0;
    n_frame = 0;
  endtask

  task automatic pulse(input logic [7:0] i, input logic [7:0] q, input logic am);
    corr_valid = 1'b1; corr_i = i; corr_q = q; am_bit = am;
    @(negedge clk);
    corr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ssp_clk", ssp_clk, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single frame at P=2; clk_div/snoop changed mid-frame must not affect it.
    cap_q.delete(); n_pulse = 0; n_frame = 0;
    pulse(8'h5A, 8'hC3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("lat_frame_t2", ssp_frame, 0);
    @(negedge clk);
    chk("lat_frame_t3", ssp_frame, 1);
    chk("lat_din_t3", ssp_din, 0);
    repeat (8) @(negedge clk);
    clk_div = 2'd1; snoop = 1'b1;
    wait_idle(200);
    clk_div = 2'd0; snoop = 1'b0;
    chk("f1_count", cap_q.size(), 1);
    chk("f1_word", (cap_q.size() > 0) ? cap_q[0] : 0, 16'h5AC3);
    chk("f1_pulses", n_pulse, 16);
    chk("f1_frames", n_frame, 1);

    // Snoop embedding of AM bits.
    do_reset();
    snoop = 1'b1;
    pulse(8'h12, 8'h34, 1'b1);
    pulse(8'hFF, 8'h00, 1'b0);
    wait_idle(300);
    snoop = 1'b0;
    chk("snoop_count", cap_q.size(), 2);
    chk("snoop_w0", (cap_q.size() > 0) ? cap_q[0] : 0, 16'h1235);
    chk("snoop_w1", (cap_q.size() > 1) ? cap_q[1] : 0, 16'hFF00);

    // Overflow: 6 pushes 2 cycles apart into DEPTH=4 at P=16.
    do_reset();
    clk_div = 2'd3;
    for (int n = 1; n <= 6; n++) begin
      pulse(8'(n), 8'(8'h10 + n), 1'b0);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 1);
    wait_idle(3000);
    chk("ovf_frames", cap_q.size(), 5);
    for (int n = 0; n < 5; n++)
      chk("ovf_order", (cap_q.size() > n) ? cap_q[n] : 0, {8'(n + 1), 8'(8'h11 + n)});

    // Full FIFO with a push landing on the LOAD pop at P=2.
    do_reset();
    clk_div = 2'd0;
    corr_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      corr_i = 8'(8'hA0 + n); corr_q = 8'(n);
      @(negedge clk);
    end
    corr_valid = 1'b0;
    repeat (32) @(negedge clk);
    chk("full_busy", busy, 1);
    corr_valid = 1'b1; corr_i = 8'hA5; corr_q = 8'h05;
    @(negedge clk);
    corr_valid = 1'b0;
    @(negedge clk);
    chk("full_pop_drops", drop_count, 0);
    chk("full_pop_ovf", overflow, 0);
    wait_idle(400);
    chk("full_frames", cap_q.size(), 6);
    for (int n = 0; n < 6; n++)
      chk("full_order", (cap_q.size() > n) ? cap_q[n] : 0, {8'(8'hA0 + n), 8'(n)});

    // Asynchronous reset while bit 7 is on the wire.
    do_reset();
    clk_div = 2'd1;
    pulse(8'h00, 8'h80, 1'b0);
    repeat (37) @(negedge clk);
    chk("b7_clk", ssp_clk, 1);
    chk("b7_din", ssp_din, 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_clk", ssp_clk, 0);
    chk("arst_din", ssp_din, 0);
    chk("arst_frame", ssp_frame, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    pulse(8'h12, 8'h34, 1'b0);
    wait_idle(300);
    chk("post_rst_count", cap_q.size(), 1);
    chk("post_rst_word", (cap_q.size() > 0) ? cap_q[0] : 0, 16'h1234);

    // Saturating drop counter, then clear coinciding with a drop.
    do_reset();
    clk_div = 2'd3;
    corr_valid = 1'b1;
    for (int n = 0; n < 310; n++) begin
      corr_i = 8'(n); corr_q = 8'(~n);
      @(negedge clk);
    end
    chk("sat_drops", drop_count, 255);
    chk("sat_ovf", overflow, 1);
    clr_ovf = 1'b1; corr_valid = 1'b0;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_drops", drop_count, 0);
    do_reset();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
